pilha_lifo: RTL and testbench

Parametrised hardware LIFO stack, the successor to the fixed 16x64 addressed `Pilha` memory. It replaces external addressing with an internal stack pointer and push/pop handshake, and adds occupancy, full/empty status and overflow/underflow detection. It is the processor's return-address/operand stack, fed by the control unit and read by the ALU datapath.

---
 rtl/pilha_pkg.sv | 22 ++
 rtl/pilha_mem.sv | 42 ++++
 rtl/pilha_lifo.sv | 173 +++++++++++++++++
 tb/tb_pilha_lifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pilha_pkg.sv
// rtl/pilha_pkg.sv - shared op-codes and address-width helper for the pilha_lifo stack
//
// Purpose : op-code constants decoded from {push, pop}, and the function that
//           derives the stack-pointer address width from the stack depth.
// Ports   : none (package).
// Config  : PILHA_ERRO_EN selects sticky error flags in pilha_lifo.

package pilha_pkg;

    // Operation codes, indexed as {push, pop}.
    localparam logic [1:0] OP_NADA  = 2'b00;
    localparam logic [1:0] OP_POP   = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_TROCA = 2'b11;

    // Address width for a stack of 'prof' entries. A depth of 1 would give
    // $clog2 = 0, so keep at least one address bit.
    function automatic int pilha_end_w(input int prof);
        return (prof > 1) ? $clog2(prof) : 1;
    endfunction

endpackage : pilha_pkg

// File: rtl/pilha_mem.sv
// rtl/pilha_mem.sv - register-array storage for the LIFO stack, 1 sync write / 1 async read
//
// Purpose : LARGURA x PROFUNDIDADE word array. Contents are never reset.
// Ports   : clk       - rising-edge clock
//           we_i      - write enable
//           waddr_i   - write address
//           wdata_i   - write data
//           raddr_i   - read address (combinational read)
//           rdata_o   - read data; zero when raddr_i is beyond the last entry
// Config  : none.

module pilha_mem #(
    parameter int LARGURA      = 16,
    parameter int PROFUNDIDADE = 64,
    parameter int END_W        = 6
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [END_W-1:0]   waddr_i,
    input  logic [LARGURA-1:0] wdata_i,
    input  logic [END_W-1:0]   raddr_i,
    output logic [LARGURA-1:0] rdata_o
);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // When the stack is empty the top address wraps to all ones, which for a
    // non-power-of-two depth points past the array; return zero instead.
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < PROFUNDIDADE) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule : pilha_mem

// File: rtl/pilha_lifo.sv
// rtl/pilha_lifo.sv - parametrised LIFO stack with push/pop handshake and status flags
//
// Purpose : return-address/operand stack. Holds the stack pointer, decodes the
//           {push,pop} operation, registers the popped word and the error flags.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           push, pop         - operation request (both = replace / bypass)
//           dado_in           - word to push
//           dado_out          - registered popped word
//           dado_valido       - one-cycle pulse qualifying dado_out
//           topo              - combinational peek at the top entry
//           ocupacao          - number of stored entries
//           cheia, vazia      - full / empty status
//           erro_ovf/erro_udf - overflow / underflow flags
//           limpa_erro        - synchronous clear of both error flags
// Config  : PILHA_ERRO_EN defined -> sticky error flags;
//           undefined -> flags tied to 0 and limpa_erro ignored.

module pilha_lifo
    import pilha_pkg::*;
#(
    parameter  int LARGURA      = 16,
    parameter  int PROFUNDIDADE = 64,
    localparam int END_W        = pilha_end_w(PROFUNDIDADE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dado_in,
    output logic [LARGURA-1:0] dado_out,
    output logic               dado_valido,
    output logic [LARGURA-1:0] topo,
    output logic [END_W:0]     ocupacao,
    output logic               cheia,
    output logic               vazia,
    output logic               erro_ovf,
    output logic               erro_udf,
    input  logic               limpa_erro
);

    localparam logic [END_W:0] SP_UM    = (END_W+1)'(1);
    localparam logic [END_W:0] SP_CHEIO = (END_W+1)'(PROFUNDIDADE);

    logic [END_W:0]     sp_q, sp_d;
    logic [LARGURA-1:0] dado_out_q, dado_out_d;
    logic               dado_valido_q, dado_valido_d;

    logic               mem_we;
    logic [END_W-1:0]   mem_waddr;
    logic [END_W-1:0]   mem_raddr;
    logic [LARGURA-1:0] mem_rdata;

    logic [1:0]         op;
    logic               ovf_ev, udf_ev;
    logic               cheia_w, vazia_w;

    // Status is derived from the pointer alone.
    assign cheia_w  = (sp_q == SP_CHEIO);
    assign vazia_w  = (sp_q == '0);
    assign ocupacao = sp_q;
    assign cheia    = cheia_w;
    assign vazia    = vazia_w;

    // The top entry lives at sp-1; the same read port feeds topo and pops.
    assign mem_raddr = END_W'(sp_q - SP_UM);
    assign topo      = mem_rdata;

    assign op = {push, pop};

    pilha_mem #(
        .LARGURA      (LARGURA),
        .PROFUNDIDADE (PROFUNDIDADE),
        .END_W        (END_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (dado_in),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        sp_d          = sp_q;
        dado_out_d    = dado_out_q;
        dado_valido_d = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = sp_q[END_W-1:0];
        ovf_ev        = 1'b0;
        udf_ev        = 1'b0;

        case (op)
            OP_PUSH: begin
                if (!cheia_w) begin
                    mem_we = 1'b1;
                    sp_d   = sp_q + SP_UM;
                end else begin
                    ovf_ev = 1'b1;
                end
            end
            OP_POP: begin
                if (!vazia_w) begin
                    dado_out_d    = mem_rdata;
                    dado_valido_d = 1'b1;
                    sp_d          = sp_q - SP_UM;
                end else begin
                    udf_ev = 1'b1;
                end
            end
            OP_TROCA: begin
                // Replace the top in place (legal even when full); on an empty
                // stack the incoming word passes straight through.
                dado_valido_d = 1'b1;
                if (!vazia_w) begin
                    dado_out_d = mem_rdata;
                    mem_we     = 1'b1;
                    mem_waddr  = mem_raddr;
                end else begin
                    dado_out_d = dado_in;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q          <= '0;
            dado_out_q    <= '0;
            dado_valido_q <= 1'b0;
        end else begin
            sp_q          <= sp_d;
            dado_out_q    <= dado_out_d;
            dado_valido_q <= dado_valido_d;
        end
    end

    assign dado_out    = dado_out_q;
    assign dado_valido = dado_valido_q;

`ifdef PILHA_ERRO_EN
    logic erro_ovf_q, erro_udf_q;

    // A new event takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            erro_ovf_q <= 1'b0;
            erro_udf_q <= 1'b0;
        end else begin
            if (ovf_ev) begin
                erro_ovf_q <= 1'b1;
            end else if (limpa_erro) begin
                erro_ovf_q <= 1'b0;
            end
            if (udf_ev) begin
                erro_udf_q <= 1'b1;
            end else if (limpa_erro) begin
                erro_udf_q <= 1'b0;
            end
        end
    end

    assign erro_ovf = erro_ovf_q;
    assign erro_udf = erro_udf_q;
`else
    logic unused_erro;
    assign unused_erro = limpa_erro ^ ovf_ev ^ udf_ev;
    assign erro_ovf    = 1'b0;
    assign erro_udf    = 1'b0;
`endif

endmodule : pilha_lifo

// File: tb/tb_pilha_lifo.sv
// tb/tb_pilha_lifo.sv - self-checking bench for pilha_lifo (64x16 and 5x8 instances)

module tb_pilha_lifo;

`ifdef PILHA_ERRO_EN
    localparam bit ERRO_EN = 1'b1;
`else
    localparam bit ERRO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        push_a = 1'b0, pop_a = 1'b0, limpa_a = 1'b0;
    logic [15:0] din_a  = '0;
    logic [15:0] dout_a, topo_a;
    logic [6:0]  occ_a;
    logic        dv_a, cheia_a, vazia_a, ovf_a, udf_a;

    logic        push_b = 1'b0, pop_b = 1'b0, limpa_b = 1'b0;
    logic [7:0]  din_b  = '0;
    logic [7:0]  dout_b, topo_b;
    logic [3:0]  occ_b;
    logic        dv_b, cheia_b, vazia_b, ovf_b, udf_b;

    pilha_lifo #(.LARGURA(16), .PROFUNDIDADE(64)) dut_a (
        .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .dado_in(din_a),
        .dado_out(dout_a), .dado_valido(dv_a), .topo(topo_a), .ocupacao(occ_a),
        .cheia(cheia_a), .vazia(vazia_a), .erro_ovf(ovf_a), .erro_udf(udf_a),
        .limpa_erro(limpa_a)
    );

    pilha_lifo #(.LARGURA(8), .PROFUNDIDADE(5)) dut_b (
        .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .dado_in(din_b),
        .dado_out(dout_b), .dado_valido(dv_b), .topo(topo_b), .ocupacao(occ_b),
        .cheia(cheia_b), .vazia(vazia_b), .erro_ovf(ovf_b), .erro_udf(udf_b),
        .limpa_erro(limpa_b)
    );

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model: stack contents, scoreboard of expected popped words,
    // last valid output word, sticky error flags.
    logic [15:0] stk [$];
    logic [15:0] sb  [$];
    logic [15:0] last_out;
    bit          ovf_m, udf_m;
    bit          sel_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        stk.delete();
        sb.delete();
        last_out = '0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
    endtask

    // One clock of stimulus on the selected instance, followed by checks.
    task automatic op(input bit p, input bit q, input bit l, input logic [15:0] d);
        int          depth;
        logic [15:0] dm;
        bit          v, eo, eu;
        logic [31:0] o_out, o_topo, o_occ;
        logic        o_v, o_cheia, o_vazia, o_ovf, o_udf;
        depth = sel_b ? 5 : 64;
        dm    = sel_b ? {8'h00, d[7:0]} : d;
        v = 1'b0; eo = 1'b0; eu = 1'b0;
        case ({p, q})
            2'b10: if (stk.size() < depth) stk.push_back(dm); else eo = 1'b1;
            2'b01: begin
                if (stk.size() > 0) begin sb.push_back(stk.pop_back()); v = 1'b1; end
                else eu = 1'b1;
            end
            2'b11: begin
                v = 1'b1;
                if (stk.size() > 0) begin sb.push_back(stk[$]); stk[$] = dm; end
                else sb.push_back(dm);
            end
            default: ;
        endcase
        if (eo) ovf_m = 1'b1; else if (l) ovf_m = 1'b0;
        if (eu) udf_m = 1'b1; else if (l) udf_m = 1'b0;

        if (sel_b) begin push_b = p; pop_b = q; limpa_b = l; din_b = d[7:0]; end
        else       begin push_a = p; pop_a = q; limpa_a = l; din_a = d; end
        @(posedge clk);
        #1;
        push_a = 1'b0; pop_a = 1'b0; limpa_a = 1'b0;
        push_b = 1'b0; pop_b = 1'b0; limpa_b = 1'b0;

        if (sel_b) begin
            o_out = {24'h0, dout_b}; o_topo = {24'h0, topo_b}; o_occ = {28'h0, occ_b};
            o_v = dv_b; o_cheia = cheia_b; o_vazia = vazia_b; o_ovf = ovf_b; o_udf = udf_b;
        end else begin
            o_out = {16'h0, dout_a}; o_topo = {16'h0, topo_a}; o_occ = {25'h0, occ_a};
            o_v = dv_a; o_cheia = cheia_a; o_vazia = vazia_a; o_ovf = ovf_a; o_udf = udf_a;
        end

        if (v && sb.size() > 0) last_out = sb.pop_front();
        chk("dado_valido", {31'h0, o_v}, {31'h0, v});
        chk("dado_out", o_out, {16'h0, last_out});
        chk("ocupacao", o_occ, stk.size());
        chk("vazia", {31'h0, o_vazia}, {31'h0, (stk.size() == 0)});
        chk("cheia", {31'h0, o_cheia}, {31'h0, (stk.size() == depth)});
        if (stk.size() > 0) chk("topo", o_topo, {16'h0, stk[$]});
        chk("erro_ovf", {31'h0, o_ovf}, {31'h0, ERRO_EN & ovf_m});
        chk("erro_udf", {31'h0, o_udf}, {31'h0, ERRO_EN & udf_m});
    endtask

    initial begin
        model_clear();
        sel_b = 1'b0;

        // Reset state.
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ocupacao", {25'h0, occ_a}, 32'd0);
        chk("rst_vazia", {31'h0, vazia_a}, 32'd1);
        chk("rst_cheia", {31'h0, cheia_a}, 32'd0);
        chk("rst_dado_out", {16'h0, dout_a}, 32'd0);
        chk("rst_valido", {31'h0, dv_a}, 32'd0);
        chk("rst_ovf", {31'h0, ovf_a}, 32'd0);
        chk("rst_udf", {31'h0, udf_a}, 32'd0);
        chk("rst_b_vazia", {31'h0, vazia_b}, 32'd1);
        rst = 1'b0;

        // Fill to capacity, then overflow.
        for (int i = 1; i <= 64; i++) op(1'b1, 1'b0, 1'b0, 16'(i));
        chk("full_cheia", {31'h0, cheia_a}, 32'd1);
        chk("full_topo", {16'h0, topo_a}, 32'h0040);
        op(1'b1, 1'b0, 1'b0, 16'hBEEF);
        chk("ovf_topo", {16'h0, topo_a}, 32'h0040);

        // Drain in reverse order.
        for (int i = 0; i < 64; i++) op(1'b0, 1'b1, 1'b0, 16'h0);
        op(1'b0, 1'b0, 1'b0, 16'h0);

        // Underflow, clear racing a new event, then a plain clear.
        op(1'b0, 1'b1, 1'b0, 16'h0);
        op(1'b0, 1'b1, 1'b1, 16'h0);
        op(1'b0, 1'b0, 1'b1, 16'h0);

        // Replace on a two-deep stack, then bypass on an empty one.
        op(1'b1, 1'b0, 1'b0, 16'h1111);
        op(1'b1, 1'b0, 1'b0, 16'h2222);
        op(1'b1, 1'b1, 1'b0, 16'h3333);
        chk("troca_topo", {16'h0, topo_a}, 32'h3333);
        op(1'b0, 1'b1, 1'b0, 16'h0);
        op(1'b0, 1'b1, 1'b0, 16'h0);
        op(1'b1, 1'b1, 1'b0, 16'h5A5A);
        chk("bypass_vazia", {31'h0, vazia_a}, 32'd1);

        // Replace while full raises no overflow.
        for (int i = 0; i < 64; i++) op(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        op(1'b1, 1'b1, 1'b1, 16'hCAFE);

        // Asynchronous reset mid-operation with a push in flight.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 1'b0, 16'(16'h00A0 + i));
        op(1'b0, 1'b1, 1'b0, 16'h0);
        push_a = 1'b1; din_a = 16'h0099;
        #2 rst = 1'b1;
        #1;
        chk("arst_vazia", {31'h0, vazia_a}, 32'd1);
        chk("arst_valido", {31'h0, dv_a}, 32'd0);
        chk("arst_dado_out", {16'h0, dout_a}, 32'd0);
        @(posedge clk); #1;
        chk("arst_push_discard", {25'h0, occ_a}, 32'd0);
        push_a = 1'b0; rst = 1'b0;
        model_clear();
        op(1'b1, 1'b0, 1'b0, 16'h0007);
        chk("post_rst_topo", {16'h0, topo_a}, 32'h0007);

        // Small instance: 6 pushes into 5 slots, then random traffic.
        sel_b = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) op(1'b1, 1'b0, 1'b0, 16'(8'h10 + i));
        chk("b_ocupacao", {28'h0, occ_b}, 32'd5);
        for (int i = 0; i < 32; i++)
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule : tb_pilha_lifo
